pkt_ingress_buf: RTL and testbench
==================================

PKT_INGRESS_BUF -- requirements
Module: pkt_ingress_buf

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the Avalon-ST data width in bits.
REQ-002 The block SHALL have parameter EMPTY_WIDTH, default 6, meaning the width of the empty field; it equals $clog2(DATA_WIDTH).
REQ-003 The block SHALL have parameter DEPTH, default 64, meaning the buffer depth in beats; it is a power of 2 and at least 4.
REQ-004 clk  input  1  core clock; all logic is in this single domain.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_ready  output  1  upstream backpressure.
REQ-007 in_valid  input  1  upstream beat valid.
REQ-008 in_startofpacket  input  1  first beat of packet.
REQ-009 in_endofpacket  input  1  last beat of packet.
REQ-010 in_data  input  DATA_WIDTH  beat payload.
REQ-011 in_empty  input  EMPTY_WIDTH  unused bytes on eop beat.
REQ-012 in_error  input  1  packet error, sampled on the eop beat.
REQ-013 out_ready, out_valid, out_startofpacket, out_endofpacket, out_data, out_empty, out_error SHALL mirror the in_* set with directions reversed, feeding the feed decoder input.
REQ-014 pkt_count  output  16  committed packets, wraps.
REQ-015 drop_count  output  16  dropped packets, saturates at 0xFFFF.

Function
REQ-016 A beat SHALL transfer when valid and ready are both high; in_ready SHALL be 1 in every cycle after reset, so ingress never stalls.
REQ-017 The write side SHALL use three states: IDLE (between packets), PKT (storing), DROP (discarding until eop).
REQ-018 IDLE + sop beat -> store beat; an sop+eop beat goes to the commit rule, otherwise -> PKT. IDLE + non-sop beat -> discard, stay IDLE, no count change.
REQ-019 PKT + beat: store; on eop with in_error=0, commit and go to IDLE; on eop with in_error=1, rewind the speculative pointer to the committed pointer, increment drop_count and go to IDLE.
REQ-020 PKT + sop beat (missing eop): rewind, increment drop_count, then treat the beat as a fresh IDLE sop beat in the same cycle.
REQ-021 A beat that would make stored plus speculative words exceed DEPTH SHALL NOT be written; rewind and increment drop_count; eop on that beat -> IDLE, otherwise -> DROP.
REQ-022 DROP SHALL discard all beats; eop -> IDLE; sop -> treated as IDLE sop beat.
REQ-023 Commit SHALL set the committed pointer to speculative+1 and increment pkt_count.
REQ-024 Pointers SHALL be log2(DEPTH)+1 bits with wrap-around; full = (spec - rd) == DEPTH; empty = (committed == rd).
REQ-025 Each stored word SHALL hold {sop, eop, empty, data}; out_error SHALL always be 0.
REQ-026 Output SHALL be a registered stage: out_* change only when out_valid=0 or out_ready=1; a held beat stays stable while out_ready=0.
REQ-027 Latency: a commit in cycle N with the output stage empty SHALL give out_valid=1 with the sop beat in cycle N+2.
REQ-028 With out_ready held at 1, the block SHALL emit one beat per cycle; committed packets SHALL leave in arrival order, back to back.
REQ-029 A read freeing a word in the same cycle as a write SHALL NOT count as free space until the next cycle (conservative full).

Reset
REQ-030 While reset_n=0: all pointers 0, state IDLE, out_valid 0, out_sop/eop/empty/data/error 0, pkt_count 0, drop_count 0, in_ready 0.
REQ-031 Reset mid-packet SHALL discard all stored and speculative data; nothing partial is emitted after release.
REQ-032 in_ready SHALL go to 1 in the first clk edge after reset_n deasserts.

Structure
REQ-033 Constants and the stored-word struct type (sop, eop, empty, data) SHALL live in the shared feed package; the state enum SHALL be local.
REQ-034 Storage SHALL be one sub-module, pkt_buf_ram: a simple dual-port RAM with 1-cycle read latency, inferable as block RAM.

Verification
REQ-035 3-beat good packet (data 0x11,0x22,0x33, empty 2 on eop), out_ready=1 -> same three beats starting 2 cycles after eop, empty=2, pkt_count=1.
REQ-036 4-beat packet with in_error=1 on eop, followed by a good 2-beat packet -> only the 2-beat packet emitted; drop_count=1, pkt_count=1.
REQ-037 DEPTH=64, out_ready=0, 70-beat packet -> no output, drop_count=1; then a 5-beat packet -> emitted intact once out_ready=1.
REQ-038 sop, beat, then sop (no eop), then 1 beat with eop -> one 2-beat packet emitted from the second sop; drop_count=1.
REQ-039 Reset asserted mid-packet with 2 committed packets buffered -> after release out_valid stays 0, both counters 0.
REQ-040 Random out_ready toggling over 1000 random packets -> output stream equals the scoreboard of good packets; drop_count saturates at 0xFFFF if forced.

Source files
------------

// File: rtl/pkt_ingress_buf_pkg.sv
// Shared feed types for the ingress buffer: stored-word layout and a
// saturating counter helper.
package pkt_ingress_buf_pkg;

  // Word fields are sized for the widest supported stream; narrower
  // instances zero-pad the upper bits.
  localparam int PKT_DATA_W  = 64;
  localparam int PKT_EMPTY_W = 6;

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [PKT_EMPTY_W-1:0] empty;
    logic [PKT_DATA_W-1:0]  data;
  } pkt_word_t;

  localparam int PKT_WORD_W = $bits(pkt_word_t);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/pkt_ingress_buf_ram.sv
// Simple dual-port buffer RAM, one write port and one registered read port.
module pkt_buf_ram #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset on the array or read register so the tools can map it to block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pkt_ingress_buf.sv
// Ingress packet buffer: stores Avalon-ST packets speculatively and only
// releases complete, error-free packets to the feed decoder.
module pkt_ingress_buf
  import pkt_ingress_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int EMPTY_WIDTH = 6,
  parameter int DEPTH       = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic                   in_startofpacket,
  input  logic                   in_endofpacket,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [EMPTY_WIDTH-1:0] in_empty,
  input  logic                   in_error,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_startofpacket,
  output logic                   out_endofpacket,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [EMPTY_WIDTH-1:0] out_empty,
  output logic                   out_error,
  output logic [15:0]            pkt_count,
  output logic [15:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic [1:0] {IDLE, PKT, DROP} wr_state_t;

  wr_state_t         state;
  logic [PW-1:0]     wr_spec;
  logic [PW-1:0]     wr_commit;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     base;
  logic              beat;
  logic              abandon;
  logic              store_try;
  logic              full;
  logic              overflow;
  logic              wr_en;
  logic              eop_ok;
  logic              eop_bad;
  logic [1:0]        drop_inc;
  pkt_word_t         wr_word;

  logic              not_empty;
  logic              out_load;
  logic              rd_en;
  logic              q_valid;
  logic [PKT_WORD_W-1:0] ram_rd_data;
  pkt_word_t         ram_q;

  // Beat classification; a sop arriving mid-packet first abandons the open
  // packet, so its store starts from the committed pointer.
  always_comb begin
    beat      = in_valid && in_ready;
    abandon   = beat && (state == PKT) && in_startofpacket;
    store_try = beat && (in_startofpacket || (state == PKT));
    base      = abandon ? wr_commit : wr_spec;
    full      = (base - rd_ptr) == DEPTH_P;
    overflow  = store_try && full;
    wr_en     = store_try && !full;
    eop_ok    = wr_en && in_endofpacket && !in_error;
    eop_bad   = wr_en && in_endofpacket && in_error;
    drop_inc  = {1'b0, abandon} + {1'b0, (overflow || eop_bad)};

    wr_word       = '0;
    wr_word.sop   = in_startofpacket;
    wr_word.eop   = in_endofpacket;
    wr_word.empty[EMPTY_WIDTH-1:0] = in_empty;
    wr_word.data[DATA_WIDTH-1:0]   = in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_spec    <= '0;
      wr_commit  <= '0;
      in_ready   <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      in_ready   <= 1'b1;
      drop_count <= sat_add16(drop_count, drop_inc);
      if (beat) begin
        if (overflow || eop_bad) begin
          wr_spec <= wr_commit;
          state   <= in_endofpacket ? IDLE : DROP;
        end else if (eop_ok) begin
          wr_spec   <= base + ONE_P;
          wr_commit <= base + ONE_P;
          pkt_count <= pkt_count + 16'd1;
          state     <= IDLE;
        end else if (wr_en) begin
          wr_spec <= base + ONE_P;
          state   <= PKT;
        end else if ((state == DROP) && in_endofpacket) begin
          state <= IDLE;
        end
      end
    end
  end

  // Read side: RAM read register plus output register form a two-deep
  // pipeline, so a read is issued whenever the RAM register will be free.
  always_comb begin
    not_empty = wr_commit != rd_ptr;
    out_load  = !out_valid || out_ready;
    rd_en     = not_empty && (!q_valid || out_load);
    ram_q     = ram_rd_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr            <= '0;
      q_valid           <= 1'b0;
      out_valid         <= 1'b0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_empty         <= '0;
      out_data          <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + ONE_P;
      if (rd_en) q_valid <= 1'b1;
      else if (out_load) q_valid <= 1'b0;
      if (out_load) begin
        out_valid <= q_valid;
        if (q_valid) begin
          out_startofpacket <= ram_q.sop;
          out_endofpacket   <= ram_q.eop;
          out_empty         <= ram_q.empty[EMPTY_WIDTH-1:0];
          out_data          <= ram_q.data[DATA_WIDTH-1:0];
        end
      end
    end
  end

  assign out_error = 1'b0;

  pkt_buf_ram #(
    .WIDTH (PKT_WORD_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (base[AW-1:0]),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (ram_rd_data)
  );

endmodule

// File: tb/tb_pkt_ingress_buf.sv
// Self-checking bench for pkt_ingress_buf: directed packet scenarios plus a
// randomized run, all output beats checked against a scoreboard queue.
module tb_pkt_ingress_buf;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [5:0] empty;
    logic [63:0] data;
  } exp_beat_t;

  logic        clk;
  logic        reset_n;
  logic        in_ready;
  logic        in_valid;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [63:0] in_data;
  logic [5:0]  in_empty;
  logic        in_error;
  logic        out_ready;
  logic        out_valid;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [63:0] out_data;
  logic [5:0]  out_empty;
  logic        out_error;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;

  logic        ready_rand;
  logic        ready_level;
  logic        rand_bit;
  int          num_checks;
  int          num_fails;
  exp_beat_t   exp_q[$];
  logic        held_valid;
  logic [72:0] held_vec;
  logic [72:0] cur_vec;
  exp_beat_t   exp_b;

  pkt_ingress_buf #(.DATA_WIDTH(64), .EMPTY_WIDTH(6), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_data           (in_data),
    .in_empty          (in_empty),
    .in_error          (in_error),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_data          (out_data),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .pkt_count         (pkt_count),
    .drop_count        (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_ready = ready_rand ? rand_bit : ready_level;

  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitor: every handshake pops the scoreboard, and a held beat
  // must not change while out_ready is low.
  always @(negedge clk) begin
    if (!reset_n) begin
      held_valid = 1'b0;
    end else begin
      cur_vec = {out_startofpacket, out_endofpacket, out_error, out_empty, out_data};
      if (held_valid)
        checkOutput("hold", {6'b0, out_valid, cur_vec}, {6'b0, 1'b1, held_vec});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_beat", {6'b0, out_valid, cur_vec}, 80'd0);
        end else begin
          exp_b = exp_q.pop_front();
          checkOutput("beat", {7'b0, cur_vec},
                      {7'b0, exp_b.sop, exp_b.eop, 1'b0, exp_b.empty, exp_b.data});
        end
      end
      held_valid = out_valid && !out_ready;
      held_vec   = cur_vec;
    end
  end

  task automatic applyStimulus(input logic sop, input logic eop, input logic [63:0] data,
                               input logic [5:0] empty, input logic err);
    in_valid         = 1'b1;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_data          = data;
    in_empty         = empty;
    in_error         = err;
    @(posedge clk);
    #1;
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
    in_error         = 1'b0;
  endtask

  task automatic pushExp(input logic sop, input logic eop, input logic [5:0] empty, input logic [63:0] data);
    exp_beat_t b;
    b.sop = sop; b.eop = eop; b.empty = empty; b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic sendPacket(input int len, input logic err);
    logic        sop;
    logic        eop;
    logic [63:0] data;
    logic [5:0]  empty;
    for (int i = 0; i < len; i++) begin
      sop   = (i == 0);
      eop   = (i == len - 1);
      data  = {$urandom, $urandom};
      empty = eop ? 6'($urandom_range(0, 7)) : 6'd0;
      if (!err) pushExp(sop, eop, empty, data);
      applyStimulus(sop, eop, data, empty, eop && err);
    end
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int max_cycles);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 80'(exp_q.size()), 80'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    num_checks = 0; num_fails = 0;
    ready_rand = 1'b0; ready_level = 1'b0; held_valid = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_startofpacket = 1'b0; in_endofpacket = 1'b0;
    in_data = '0; in_empty = '0; in_error = 1'b0;

    // Reset state and in_ready release timing
    @(negedge clk);
    checkOutput("rst_in_ready", 80'(in_ready), 80'd0);
    checkOutput("rst_out", {6'b0, out_valid, out_startofpacket, out_endofpacket, out_error, out_empty, out_data}, 80'd0);
    checkOutput("rst_counts", {48'b0, pkt_count, drop_count}, 80'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_pre", 80'(in_ready), 80'd0);
    @(negedge clk);
    checkOutput("in_ready_post", 80'(in_ready), 80'd1);

    // Good 3-beat packet, latency and back-to-back output
    doReset();
    ready_level = 1'b1;
    pushExp(1, 0, 6'd0, 64'h11); applyStimulus(1, 0, 64'h11, 6'd0, 0);
    pushExp(0, 0, 6'd0, 64'h22); applyStimulus(0, 0, 64'h22, 6'd0, 0);
    pushExp(0, 1, 6'd2, 64'h33); applyStimulus(0, 1, 64'h33, 6'd2, 0);
    @(negedge clk); checkOutput("lat_n0", 80'(out_valid), 80'd0);
    @(negedge clk); checkOutput("lat_n1", 80'(out_valid), 80'd0);
    @(negedge clk); checkOutput("lat_n2", 80'({out_valid, out_startofpacket}), 80'd3);
    @(negedge clk); checkOutput("b2b_1", 80'(out_valid), 80'd1);
    @(negedge clk); checkOutput("b2b_2", 80'({out_valid, out_endofpacket}), 80'd3);
    waitDrain(50);
    checkOutput("t1_counts", {48'b0, pkt_count, drop_count}, {48'b0, 16'd1, 16'd0});

    // Errored packet dropped, following good packet kept
    doReset();
    applyStimulus(1, 0, 64'hA1, 6'd0, 0);
    applyStimulus(0, 0, 64'hA2, 6'd0, 0);
    applyStimulus(0, 0, 64'hA3, 6'd0, 0);
    applyStimulus(0, 1, 64'hA4, 6'd1, 1);
    pushExp(1, 0, 6'd0, 64'hB1); applyStimulus(1, 0, 64'hB1, 6'd0, 0);
    pushExp(0, 1, 6'd5, 64'hB2); applyStimulus(0, 1, 64'hB2, 6'd5, 0);
    waitDrain(50);
    checkOutput("t2_counts", {48'b0, pkt_count, drop_count}, {48'b0, 16'd1, 16'd1});

    // Overflow: 70 beats with no reads, then 5-beat packet, then an exact-fit packet
    doReset();
    ready_level = 1'b0;
    for (int i = 0; i < 70; i++) applyStimulus(i == 0, i == 69, 64'(i + 1000), 6'd0, 0);
    repeat (4) @(negedge clk);
    checkOutput("ovf_no_out", 80'(out_valid), 80'd0);
    checkOutput("ovf_drop", 80'(drop_count), 80'd1);
    sendPacket(5, 0);
    repeat (6) @(negedge clk);
    ready_level = 1'b1;
    waitDrain(50);
    ready_level = 1'b0;
    sendPacket(DEPTH, 0);
    checkOutput("fit_counts", {48'b0, pkt_count, drop_count}, {48'b0, 16'd2, 16'd1});
    ready_level = 1'b1;
    waitDrain(200);

    // Missing eop: second sop restarts the packet
    doReset();
    applyStimulus(1, 0, 64'hC1, 6'd0, 0);
    applyStimulus(0, 0, 64'hC2, 6'd0, 0);
    pushExp(1, 0, 6'd0, 64'hD1); applyStimulus(1, 0, 64'hD1, 6'd0, 0);
    pushExp(0, 1, 6'd3, 64'hD2); applyStimulus(0, 1, 64'hD2, 6'd3, 0);
    waitDrain(50);
    checkOutput("t4_counts", {48'b0, pkt_count, drop_count}, {48'b0, 16'd1, 16'd1});

    // Reset mid-packet with committed packets buffered
    doReset();
    ready_level = 1'b0;
    sendPacket(3, 0);
    sendPacket(3, 0);
    applyStimulus(1, 0, 64'hE1, 6'd0, 0);
    applyStimulus(0, 0, 64'hE2, 6'd0, 0);
    checkOutput("pre_rst_pkts", 80'(pkt_count), 80'd2);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_out", {78'b0, out_valid, in_ready}, 80'd0);
    checkOutput("mid_rst_counts", {48'b0, pkt_count, drop_count}, 80'd0);
    @(posedge clk);
    #1;
    exp_q.delete();
    reset_n = 1'b1;
    ready_level = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("post_rst_idle", 80'(out_valid), 80'd0);
    end
    checkOutput("post_rst_counts", {48'b0, pkt_count, drop_count}, 80'd0);

    // Random packets with random backpressure
    begin
      int good;
      int bad;
      int len;
      int guard;
      logic err;
      good = 0; bad = 0;
      doReset();
      ready_rand = 1'b1;
      for (int p = 0; p < 1000; p++) begin
        len = $urandom_range(1, 5);
        err = ($urandom_range(0, 4) == 0);
        guard = 0;
        while (exp_q.size() + len > DEPTH && guard < 2000) begin
          @(posedge clk);
          #1;
          guard++;
        end
        if (guard >= 2000) checkOutput("pace_timeout", 80'(exp_q.size()), 80'd0);
        if ($urandom_range(0, 9) == 0) applyStimulus(0, 1, {$urandom, $urandom}, 6'd0, 0);
        sendPacket(len, err);
        if (err) bad++; else good++;
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      ready_rand = 1'b0;
      ready_level = 1'b1;
      waitDrain(5000);
      checkOutput("rand_pkts", 80'(pkt_count), 80'(good));
      checkOutput("rand_drops", 80'(drop_count), 80'(bad));
    end

    // drop_count saturation
    doReset();
    in_valid = 1'b1; in_startofpacket = 1'b1; in_endofpacket = 1'b1; in_error = 1'b1;
    in_data = 64'hDEAD; in_empty = 6'd0;
    repeat (65534) @(posedge clk);
    #1;
    checkOutput("sat_fffe", 80'(drop_count), 80'hFFFE);
    applyStimulus(1, 1, 64'hDEAD, 6'd0, 1);
    checkOutput("sat_ffff", 80'(drop_count), 80'hFFFF);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 64'hDEAD, 6'd0, 1);
    checkOutput("sat_hold", 80'(drop_count), 80'hFFFF);
    checkOutput("sat_no_out", {78'b0, out_valid, 1'b0} | 80'(pkt_count), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
